// File: rtl/wb_pkg.sv
// Shared constants and the default-width result entry for the writeback arbiter.
package wb_pkg;

  localparam int NREQ  = 4;
  localparam int NPORT = 2;

  localparam logic [1:0] REQ_ALU0 = 2'd0;
  localparam logic [1:0] REQ_ALU1 = 2'd1;
  localparam logic [1:0] REQ_BR   = 2'd2;
  localparam logic [1:0] REQ_MEM  = 2'd3;

  localparam int WB_PRD_W  = 7;
  localparam int WB_ROB_W  = 5;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic                 we;
    logic [WB_PRD_W-1:0]  prd;
    logic [WB_ROB_W-1:0]  rob;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry skid FIFO holding one requester's pending writeback results.
// Push and pop may coincide; flush drops everything buffered.
module wb_fifo2
  import wb_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flush,
  input  logic       i_push,
  input  entry_t     i_push_entry,
  input  logic       i_pop,
  output logic [1:0] o_count,
  output entry_t     o_head
);

  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, rd_ptr_d;
  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       push_ok, pop_ok, wr_idx;

  // The write slot sits one past the read pointer when one entry is held.
  always_comb begin
    push_ok  = i_push && (count_q != 2'd2);
    pop_ok   = i_pop && (count_q != 2'd0);
    wr_idx   = rd_ptr_q ^ count_q[0];
    mem_d    = mem_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      count_d = 2'd0;
    end else begin
      if (push_ok) mem_d[wr_idx] = i_push_entry;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: four execution-unit skid FIFOs share two registered
// writeback ports under a rotating-priority scheduler.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH_PRD  = 7,
  parameter int WIDTH_ROB  = 5,
  parameter int WIDTH_DATA = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_kill,
  input  logic [NREQ-1:0]             i_req_valid,
  output logic [NREQ-1:0]             o_req_ready,
  input  logic [NREQ-1:0]             i_req_we,
  input  logic [NREQ*WIDTH_PRD-1:0]   i_req_prd,
  input  logic [NREQ*WIDTH_ROB-1:0]   i_req_rob,
  input  logic [NREQ*WIDTH_DATA-1:0]  i_req_data,
  output logic [NPORT-1:0]            o_wb_valid,
  output logic [NPORT-1:0]            o_wb_we,
  output logic [NPORT*WIDTH_PRD-1:0]  o_wb_prd,
  output logic [NPORT*WIDTH_ROB-1:0]  o_wb_rob,
  output logic [NPORT*WIDTH_DATA-1:0] o_wb_data,
  output logic [2*NPORT-1:0]          o_wb_src
);

  typedef struct packed {
    logic                  we;
    logic [WIDTH_PRD-1:0]  prd;
    logic [WIDTH_ROB-1:0]  rob;
    logic [WIDTH_DATA-1:0] data;
  } entry_t;

  logic [1:0]       count [NREQ];
  entry_t           head  [NREQ];
  logic [NREQ-1:0]  push, pop;
  logic [1:0]       rr_q, rr_d;
  logic [NPORT-1:0] grant_valid;
  logic [1:0]       grant_id [NPORT];
  logic [1:0]       n_hits, scan_id;

  logic [NPORT-1:0]            wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [NPORT*WIDTH_PRD-1:0]  wb_prd_q, wb_prd_d;
  logic [NPORT*WIDTH_ROB-1:0]  wb_rob_q, wb_rob_d;
  logic [NPORT*WIDTH_DATA-1:0] wb_data_q, wb_data_d;
  logic [2*NPORT-1:0]          wb_src_q, wb_src_d;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    entry_t push_entry;
    assign push_entry.we   = i_req_we[g];
    assign push_entry.prd  = i_req_prd[g*WIDTH_PRD +: WIDTH_PRD];
    assign push_entry.rob  = i_req_rob[g*WIDTH_ROB +: WIDTH_ROB];
    assign push_entry.data = i_req_data[g*WIDTH_DATA +: WIDTH_DATA];
    assign o_req_ready[g]  = (count[g] != 2'd2) & ~i_rst;
    assign push[g]         = i_req_valid[g] & o_req_ready[g] & ~i_kill;

    wb_fifo2 #(.entry_t(entry_t)) u_fifo (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_flush      (i_kill),
      .i_push       (push[g]),
      .i_push_entry (push_entry),
      .i_pop        (pop[g]),
      .o_count      (count[g]),
      .o_head       (head[g])
    );
  end

  // Scan from rr; first two non-empty heads win, rr moves past the last winner.
  always_comb begin
    pop         = '0;
    rr_d        = rr_q;
    grant_valid = '0;
    grant_id[0] = 2'd0;
    grant_id[1] = 2'd0;
    n_hits      = 2'd0;
    scan_id     = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      scan_id = rr_q + 2'(k);
      if ((count[scan_id] != 2'd0) && (n_hits < 2'(NPORT))) begin
        grant_valid[n_hits[0]] = 1'b1;
        grant_id[n_hits[0]]    = scan_id;
        pop[scan_id]           = 1'b1;
        rr_d                   = scan_id + 2'd1;
        n_hits                 = n_hits + 2'd1;
      end
    end
    if (i_kill) begin
      pop  = '0;
      rr_d = rr_q;
    end
  end

  always_comb begin
    wb_valid_d = '0;
    wb_we_d    = wb_we_q;
    wb_prd_d   = wb_prd_q;
    wb_rob_d   = wb_rob_q;
    wb_data_d  = wb_data_q;
    wb_src_d   = wb_src_q;
    for (int p = 0; p < NPORT; p++) begin
      if (grant_valid[p] && !i_kill) begin
        wb_valid_d[p]                           = 1'b1;
        wb_we_d[p]                              = head[grant_id[p]].we;
        wb_prd_d[p*WIDTH_PRD +: WIDTH_PRD]      = head[grant_id[p]].prd;
        wb_rob_d[p*WIDTH_ROB +: WIDTH_ROB]      = head[grant_id[p]].rob;
        wb_data_d[p*WIDTH_DATA +: WIDTH_DATA]   = head[grant_id[p]].data;
        wb_src_d[2*p +: 2]                      = grant_id[p];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q       <= 2'd0;
      wb_valid_q <= '0;
      wb_we_q    <= '0;
      wb_prd_q   <= '0;
      wb_rob_q   <= '0;
      wb_data_q  <= '0;
      wb_src_q   <= '0;
    end else begin
      rr_q       <= rr_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_prd_q   <= wb_prd_d;
      wb_rob_q   <= wb_rob_d;
      wb_data_q  <= wb_data_d;
      wb_src_q   <= wb_src_d;
    end
  end

  assign o_wb_valid = wb_valid_q;
  assign o_wb_we    = wb_we_q;
  assign o_wb_prd   = wb_prd_q;
  assign o_wb_rob   = wb_rob_q;
  assign o_wb_data  = wb_data_q;
  assign o_wb_src   = wb_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_arbiter;

  localparam int PW = 7;
  localparam int RW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [PW-1:0] prd;
    logic [RW-1:0] rob;
    logic [DW-1:0] data;
  } ent_t;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_kill;
  logic [3:0]    i_req_valid;
  logic [3:0]    o_req_ready;
  logic [3:0]    i_req_we;
  logic [4*PW-1:0] i_req_prd;
  logic [4*RW-1:0] i_req_rob;
  logic [4*DW-1:0] i_req_data;
  logic [1:0]    o_wb_valid;
  logic [1:0]    o_wb_we;
  logic [2*PW-1:0] o_wb_prd;
  logic [2*RW-1:0] o_wb_rob;
  logic [2*DW-1:0] o_wb_data;
  logic [3:0]    o_wb_src;

  always #5 i_clk = ~i_clk;

  wb_arbiter #(.WIDTH_PRD(PW), .WIDTH_ROB(RW), .WIDTH_DATA(DW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_kill      (i_kill),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_prd   (i_req_prd),
    .i_req_rob   (i_req_rob),
    .i_req_data  (i_req_data),
    .o_wb_valid  (o_wb_valid),
    .o_wb_we     (o_wb_we),
    .o_wb_prd    (o_wb_prd),
    .o_wb_rob    (o_wb_rob),
    .o_wb_data   (o_wb_data),
    .o_wb_src    (o_wb_src)
  );

  // Reference model: one queue per requester, a round-robin index and the
  // expected contents of the writeback registers.
  ent_t        mq [4][$];
  int          m_rr;
  logic [1:0]  e_valid, e_we;
  logic [2*PW-1:0] e_prd;
  logic [2*RW-1:0] e_rob;
  logic [2*DW-1:0] e_data;
  logic [3:0]  e_src;

  // Requester side: a pending result is held until the model accepts it.
  bit   [3:0]  pend;
  ent_t        pend_ent [4];

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  function automatic ent_t mkEnt(logic we, logic [PW-1:0] prd, logic [RW-1:0] rob, logic [DW-1:0] data);
    ent_t e;
    e.we = we; e.prd = prd; e.rob = rob; e.data = data;
    return e;
  endfunction

  task automatic checkLit(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    int   pre [4];
    int   n, last, id;
    ent_t e;
    if (i_rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_rr = 0;
      e_valid = '0; e_we = '0; e_prd = '0; e_rob = '0; e_data = '0; e_src = '0;
      pend = '0;
      return;
    end
    if (i_kill) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      e_valid = '0;
      pend = '0;
      return;
    end
    for (int i = 0; i < 4; i++) pre[i] = mq[i].size();
    n = 0;
    last = -1;
    for (int k = 0; k < 4; k++) begin
      id = (m_rr + k) % 4;
      if (pre[id] > 0 && n < 2) begin
        e = mq[id].pop_front();
        e_valid[n]          = 1'b1;
        e_we[n]             = e.we;
        e_prd[n*PW +: PW]   = e.prd;
        e_rob[n*RW +: RW]   = e.rob;
        e_data[n*DW +: DW]  = e.data;
        e_src[n*2 +: 2]     = 2'(id);
        last = id;
        n++;
      end
    end
    for (int p = n; p < 2; p++) e_valid[p] = 1'b0;
    if (last >= 0) m_rr = (last + 1) % 4;
    for (int i = 0; i < 4; i++) begin
      if (i_req_valid[i] && pre[i] < 2) begin
        mq[i].push_back(pend_ent[i]);
        pend[i] = 1'b0;
      end
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < 4; i++) begin
      i_req_valid[i]           = pend[i];
      i_req_we[i]              = pend_ent[i].we;
      i_req_prd[i*PW +: PW]    = pend_ent[i].prd;
      i_req_rob[i*RW +: RW]    = pend_ent[i].rob;
      i_req_data[i*DW +: DW]   = pend_ent[i].data;
    end
  endtask

  task automatic applyStimulus(int prob);
    for (int i = 0; i < 4; i++) begin
      if (!pend[i] && ($urandom_range(99) < prob)) begin
        pend[i] = 1'b1;
        pend_ent[i] = mkEnt(1'($urandom_range(1)), PW'($urandom), RW'($urandom), $urandom);
      end
    end
    driveInputs();
  endtask

  task automatic cycle();
    @(posedge i_clk);
    modelStep();
    #1;
    driveInputs();
  endtask

  task automatic doReset();
    i_rst  = 1'b1;
    i_kill = 1'b0;
    driveInputs();
    cycle();
    i_rst = 1'b0;
  endtask

  task automatic checkOutput();
    logic [3:0] exp_ready;
    for (int i = 0; i < 4; i++) exp_ready[i] = (mq[i].size() < 2) && !i_rst;
    checkLit("wb_valid", 64'(o_wb_valid), 64'(e_valid));
    checkLit("wb_we",    64'(o_wb_we),    64'(e_we));
    checkLit("wb_prd",   64'(o_wb_prd),   64'(e_prd));
    checkLit("wb_rob",   64'(o_wb_rob),   64'(e_rob));
    checkLit("wb_data",  64'(o_wb_data),  64'(e_data));
    checkLit("wb_src",   64'(o_wb_src),   64'(e_src));
    checkLit("req_ready", 64'(o_req_ready), 64'(exp_ready));
  endtask

  always @(negedge i_clk) begin
    if (check_en) checkOutput();
  end

  initial begin
    i_rst = 1'b1;
    i_kill = 1'b0;
    pend = '0;
    for (int i = 0; i < 4; i++) pend_ent[i] = '0;
    driveInputs();
    e_valid = '0; e_we = '0; e_prd = '0; e_rob = '0; e_data = '0; e_src = '0;
    m_rr = 0;

    // Reset state and ready behaviour around deassertion.
    cycle();
    cycle();
    check_en = 1'b1;
    #1;
    checkLit("rst_ready_low", 64'(o_req_ready), 64'h0);
    checkLit("rst_valid", 64'(o_wb_valid), 64'h0);
    checkLit("rst_data", 64'(o_wb_data), 64'h0);
    i_rst = 1'b0;
    #1;
    checkLit("rst_ready_after", 64'(o_req_ready), 64'hF);

    // Single ALU0 result, two edges to the port.
    pend_ent[0] = mkEnt(1'b1, 7'd5, 5'd3, 32'hDEADBEEF);
    pend[0] = 1'b1;
    driveInputs();
    cycle();
    cycle();
    checkLit("alu0_valid", 64'(o_wb_valid), 64'h1);
    checkLit("alu0_prd", 64'(o_wb_prd[PW-1:0]), 64'd5);
    checkLit("alu0_rob", 64'(o_wb_rob[RW-1:0]), 64'd3);
    checkLit("alu0_data", 64'(o_wb_data[DW-1:0]), 64'hDEADBEEF);
    checkLit("alu0_we", 64'(o_wb_we[0]), 64'h1);
    checkLit("alu0_src", 64'(o_wb_src[1:0]), 64'h0);
    cycle();

    // All four requesters at once from rr = 0.
    doReset();
    for (int i = 0; i < 4; i++) begin
      pend_ent[i] = mkEnt(1'b1, PW'(10 + i), RW'(i), 32'(100 + i));
      pend[i] = 1'b1;
    end
    driveInputs();
    cycle();
    cycle();
    checkLit("all4_c1_valid", 64'(o_wb_valid), 64'h3);
    checkLit("all4_c1_src", 64'(o_wb_src), 64'h4);
    checkLit("all4_c1_data", 64'(o_wb_data), {32'd101, 32'd100});
    cycle();
    checkLit("all4_c2_valid", 64'(o_wb_valid), 64'h3);
    checkLit("all4_c2_src", 64'(o_wb_src), 64'hE);
    checkLit("all4_c2_data", 64'(o_wb_data), {32'd103, 32'd102});
    cycle();
    checkLit("all4_idle_valid", 64'(o_wb_valid), 64'h0);
    checkLit("all4_idle_hold", 64'(o_wb_data), {32'd103, 32'd102});

    // Continuous traffic from every requester: back-pressure alternates.
    doReset();
    applyStimulus(100);
    cycle();
    applyStimulus(100);
    cycle();
    checkLit("bp_ready_e2", 64'(o_req_ready), 64'h3);
    applyStimulus(100);
    cycle();
    checkLit("bp_ready_e3", 64'(o_req_ready), 64'hC);
    checkLit("bp_src_e3", 64'(o_wb_src), 64'hE);

    // Kill while FIFOs are full and new results are offered.
    applyStimulus(100);
    i_kill = 1'b1;
    cycle();
    i_kill = 1'b0;
    #1;
    checkLit("kill_valid", 64'(o_wb_valid), 64'h0);
    checkLit("kill_ready", 64'(o_req_ready), 64'hF);
    cycle();
    checkLit("kill_no_accept", 64'(o_wb_valid), 64'h0);

    // Reset asserted mid-stream.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(100);
      cycle();
    end
    i_rst = 1'b1;
    #1;
    checkLit("midrst_ready_low", 64'(o_req_ready), 64'h0);
    cycle();
    checkLit("midrst_valid", 64'(o_wb_valid), 64'h0);
    checkLit("midrst_data", 64'(o_wb_data), 64'h0);
    checkLit("midrst_src", 64'(o_wb_src), 64'h0);
    i_rst = 1'b0;
    #1;
    checkLit("midrst_ready_after", 64'(o_req_ready), 64'hF);
    cycle();
    checkLit("midrst_no_stale", 64'(o_wb_valid), 64'h0);

    // Random traffic with occasional kill and reset.
    for (int c = 0; c < 3000; c++) begin
      i_rst  = ($urandom_range(199) == 0);
      i_kill = !i_rst && ($urandom_range(49) == 0);
      applyStimulus((c % 400) < 200 ? 70 : 30);
      cycle();
    end
    i_rst = 1'b0;
    i_kill = 1'b0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0);
      cycle();
    end
    checkLit("drain_valid", 64'(o_wb_valid), 64'h0);
    checkLit("drain_ready", 64'(o_req_ready), 64'hF);

    @(negedge i_clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
